beep_seq_ctrl: RTL and testbench
================================

Name: beep_seq_ctrl

Overview:
- Melody sequencer that drives the buzzer tone generator.
- Holds a small programmable note table and steps through it on start.
- Presents one note code (0 = silence, 1..7 = Do..Xi) for a programmed number of beats, then a short silent gap.
- Sits between the board's control logic and the tone generator; the tone generator consumes `note` and `tone_en`.

Parameters:
- BEAT_CYCLES, 25_000_000, clock cycles per beat (500 ms at 50 MHz); minimum 1.
- GAP_CYCLES, 1_250_000, silent cycles inserted after every entry; minimum 1.
- DEPTH, 16, note table entries; power of two; address width AW = log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write note table entry.
- wr_addr  in  AW  table write address.
- wr_data  in  6  entry: [5:3] dur (plays dur+1 beats), [2:0] note code.
- last_addr  in  AW  index of final entry of the melody; sampled on accepted start.
- start  in  1  pulse; begins playback at index 0 when idle.
- stop  in  1  pulse; aborts playback.
- pause  in  1  level; freezes playback while high.
- loop  in  1  level; restart at index 0 after last entry instead of finishing.
- note  out  3  current note code to tone generator.
- tone_en  out  1  high when the tone generator should sound.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- cur_idx  out  AW  table index being played.

Behaviour:
- Clocking and reset:
  - All outputs are registered. Every register updates on the clk rising edge.
  - rst (synchronous) has top priority: state IDLE, note=0, tone_en=0, busy=0, done=0, cur_idx=0, counters=0. Table contents are not cleared.
- Table: DEPTH x 6 bits.
  - Write on wr_en at any time, including during playback.
  - A fetch and a write to the same address in the same cycle returns the old data.
  - An entry already fetched is not affected by later writes.
- FSM states: IDLE, FETCH, PLAY, GAP.
  - IDLE: start=1 and stop=0 -> latch last_addr, cur_idx=0, go to FETCH. start in any other state is ignored.
  - FETCH (1 cycle):
    - Latch note_r and beats_left=dur from table[cur_idx].
    - Clear beat counter; go to PLAY.
    - Outputs note=0, tone_en=0.
  - PLAY:
    - Outputs note=note_r, tone_en=(note_r!=0). A rest entry is timed like any note but stays silent.
    - Beat counter counts 0..BEAT_CYCLES-1.
    - At terminal count: if beats_left==0, go to GAP with the gap counter cleared; else decrement beats_left.
  - GAP:
    - Outputs note=0, tone_en=0; lasts GAP_CYCLES cycles.
    - At end: if cur_idx != latched last_addr -> cur_idx+1, go to FETCH.
    - Else if loop=1 (sampled at this cycle) -> cur_idx=0, go to FETCH.
    - Else -> done=1 for one cycle, go to IDLE.
- Timing:
  - Start sampled at edge N -> FETCH after N, PLAY after N+1. First note is visible 2 cycles after start.
  - Per-entry length is 1 + (dur+1)*BEAT_CYCLES + GAP_CYCLES cycles.
- Pause (pause=1 in FETCH/PLAY/GAP):
  - State, counters, cur_idx and beats_left hold.
  - Outputs are forced to note=0, tone_en=0; busy stays 1.
  - Playback resumes where it stopped on the cycle after pause falls.
  - pause in IDLE has no effect.
- Stop:
  - stop=1 in any non-IDLE state -> IDLE next cycle, counters cleared, cur_idx=0, no done pulse.
  - stop overrides pause and a simultaneous start.
- Widths and ranges:
  - Beat and gap counters are sized by clog2 of their parameter.
  - cur_idx wraps only through the loop path. last_addr beyond DEPTH-1 is impossible by width.
  - last_addr=0 plays a single entry.

Test Plan:
- Basic playback. BEAT_CYCLES=4, GAP_CYCLES=2. Load [0]={dur0,note1}, [1]={dur1,note3}, [2]={dur0,note0}; last_addr=2; pulse start.
  - Required: note=1, tone_en=1 for 4 cycles; 2 silent gap cycles; 1 fetch cycle; note=3 for 8 cycles; silent.
  - Entry 2 gives 4 cycles with tone_en=0.
  - done pulses exactly once, 25 cycles after FETCH is entered; busy falls the same cycle.
- Loop. Same table with loop=1.
  - Required: after the entry-2 gap, cur_idx returns to 0 with no done pulse.
  - Drop loop during the second pass -> done at the end of that pass.
- Pause mid-note. Assert pause for 10 cycles at beat-counter value 2 of note 3.
  - Required: note=0, tone_en=0, busy=1 throughout.
  - After release, note=3 resumes for exactly the remaining 6 cycles.
- Stop priority.
  - stop during PLAY -> IDLE next cycle, busy=0, done stays 0.
  - stop and start in the same IDLE cycle -> remains IDLE.
  - start while busy -> ignored, sequence unchanged.
- Write during playback. Write [1]={dur0,note7} while playing entry 1.
  - Required: entry 1 finishes with note 3 and dur1.
  - Next loop pass plays note 7 for 4 cycles.
- Reset mid-operation. Assert rst during GAP.
  - Required: all outputs 0 and IDLE the next cycle.
  - Table is retained: the next start replays the same melody.

Source files
------------

// File: rtl/beep_seq_ctrl.sv
// beep_seq_ctrl: melody sequencer feeding the buzzer tone generator.
// Steps through a small programmable note table. Each entry sounds its note
// for (dur+1) beats, followed by a fixed silent gap.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_en/addr/data   table write port; data = {dur[2:0], note[2:0]}
//   last_addr         final entry index, latched when start is accepted
//   start, stop       pulses: begin playback at index 0 / abort
//   pause, loop       levels: freeze playback / wrap to index 0 at the end
//   note, tone_en     to tone generator (registered)
//   busy, done        status: not idle / one-cycle normal-completion pulse
//   cur_idx           table index being played
module beep_seq_ctrl #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int DEPTH       = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic [AW-1:0] last_addr,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          loop,
  output logic [2:0]    note,
  output logic          tone_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_idx
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_idx_q, cur_idx_d;
  logic [AW-1:0] last_q, last_d;
  logic [2:0]    note_r_q, note_r_d;
  logic [2:0]    beats_q, beats_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]    note_q, note_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          paused;

  // Note table: no reset so contents survive rst. The asynchronous read
  // below sees the pre-write value when a write hits the fetched address.
  logic [5:0] tbl_q [DEPTH];
  logic [5:0] rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_addr] <= wr_data;
  end

  assign rd_data = tbl_q[cur_idx_q];

  // stop wins over pause; pause only matters once playback has begun
  assign paused = pause && !stop && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    last_d     = last_q;
    note_r_d   = note_r_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;

    if (stop && state_q != IDLE) begin
      state_d    = IDLE;
      cur_idx_d  = '0;
      beats_d    = '0;
      beat_cnt_d = '0;
      gap_cnt_d  = '0;
    end else if (!paused) begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            last_d    = last_addr;
            cur_idx_d = '0;
            state_d   = FETCH;
          end
        end
        FETCH: begin
          note_r_d   = rd_data[2:0];
          beats_d    = rd_data[5:3];
          beat_cnt_d = '0;
          state_d    = PLAY;
        end
        PLAY: begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            if (beats_q == 3'd0) begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end else begin
              beats_d = beats_q - 3'd1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (cur_idx_q != last_q) begin
              cur_idx_d = cur_idx_q + AW'(1);
              state_d   = FETCH;
            end else if (loop) begin
              cur_idx_d = '0;
              state_d   = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    busy_d    = (state_d != IDLE);
    note_d    = (state_d == PLAY && !paused) ? note_r_d : 3'd0;
    tone_en_d = (note_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      last_q     <= '0;
      note_r_q   <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      note_q     <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      last_q     <= last_d;
      note_r_q   <= note_r_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      note_q     <= note_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note    = note_q;
  assign tone_en = tone_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_beep_seq_ctrl.sv
// Directed bench for beep_seq_ctrl with BEAT_CYCLES=4, GAP_CYCLES=2.
// Table: [0]={dur0,note1}, [1]={dur1,note3}, [2]={dur0,rest}, last_addr=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_beep_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, stop, pause, loop;
  logic [3:0] wr_addr, last_addr, cur_idx;
  logic [5:0] wr_data;
  logic [2:0] note;
  logic       tone_en, busy, done;

  int total = 0;
  int bad   = 0;

  beep_seq_ctrl #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .start(start), .stop(stop), .pause(pause),
    .loop(loop), .note(note), .tone_en(tone_en), .busy(busy), .done(done),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n cycles, each checked for note/tone_en/busy/cur_idx and done low
  task automatic seg(input string tag, input int n, input logic [2:0] en,
                     input logic et, input logic eb, input logic [3:0] ei);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".note"},    8'(note),    8'(en));
      chk({tag, ".tone_en"}, 8'(tone_en), 8'(et));
      chk({tag, ".busy"},    8'(busy),    8'(eb));
      chk({tag, ".done"},    8'(done),    8'd0);
      chk({tag, ".cur_idx"}, 8'(cur_idx), 8'(ei));
    end
  endtask

  // Pulse start; checks the FETCH cycle of entry 0.
  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".fetch_busy"}, 8'(busy), 8'd1);
    chk({tag, ".fetch_note"}, 8'(note), 8'd0);
    chk({tag, ".fetch_idx"},  8'(cur_idx), 8'd0);
  endtask

  // The 24 cycles following the entry-0 FETCH cycle of one pass.
  task automatic play_pass(input string tag);
    seg({tag, ".n1"},   4, 3'd1, 1'b1, 1'b1, 4'd0);
    seg({tag, ".gap0"}, 2, 3'd0, 1'b0, 1'b1, 4'd0);
    seg({tag, ".f1"},   1, 3'd0, 1'b0, 1'b1, 4'd1);
    seg({tag, ".n3"},   8, 3'd3, 1'b1, 1'b1, 4'd1);
    seg({tag, ".gap1"}, 2, 3'd0, 1'b0, 1'b1, 4'd1);
    seg({tag, ".f2"},   1, 3'd0, 1'b0, 1'b1, 4'd2);
    seg({tag, ".rest"}, 4, 3'd0, 1'b0, 1'b1, 4'd2);
    seg({tag, ".gap2"}, 2, 3'd0, 1'b0, 1'b1, 4'd2);
  endtask

  task automatic chk_done(input string tag);
    tick();
    chk({tag, ".done"},    8'(done),    8'd1);
    chk({tag, ".busy"},    8'(busy),    8'd0);
    chk({tag, ".tone_en"}, 8'(tone_en), 8'd0);
    tick();
    chk({tag, ".done_low"}, 8'(done), 8'd0);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, ".busy"},    8'(busy),    8'd0);
    chk({tag, ".done"},    8'(done),    8'd0);
    chk({tag, ".note"},    8'(note),    8'd0);
    chk({tag, ".cur_idx"}, 8'(cur_idx), 8'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_addr = 4'd2;
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.note",    8'(note),    8'd0);
    chk("rst.tone_en", 8'(tone_en), 8'd0);
    chk("rst.busy",    8'(busy),    8'd0);
    chk("rst.done",    8'(done),    8'd0);
    chk("rst.cur_idx", 8'(cur_idx), 8'd0);

    wr(4'd0, 6'o01);
    wr(4'd1, 6'o13);
    wr(4'd2, 6'o00);

    // Basic playback: done 25 cycles after FETCH is entered
    do_start("basic");
    play_pass("basic");
    chk_done("basic");

    // Loop: wrap to 0 with no done, then drop loop during pass two
    loop = 1'b1;
    do_start("loop");
    play_pass("loop.p1");
    seg("loop.wrap", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    loop = 1'b0;
    play_pass("loop.p2");
    chk_done("loop");

    // Pause after two cycles of note 3; the remaining six follow release
    do_start("pause");
    seg("pause.n1",  4, 3'd1, 1'b1, 1'b1, 4'd0);
    seg("pause.gap", 2, 3'd0, 1'b0, 1'b1, 4'd0);
    seg("pause.f1",  1, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("pause.pre", 2, 3'd3, 1'b1, 1'b1, 4'd1);
    pause = 1'b1;
    seg("pause.hold", 10, 3'd0, 1'b0, 1'b1, 4'd1);
    pause = 1'b0;
    seg("pause.post", 6, 3'd3, 1'b1, 1'b1, 4'd1);
    seg("pause.gap1", 2, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("pause.f2",   1, 3'd0, 1'b0, 1'b1, 4'd2);
    do_stop("pause.stop");

    // Stop during PLAY
    do_start("stop");
    seg("stop.n1", 2, 3'd1, 1'b1, 1'b1, 4'd0);
    do_stop("stop.play");

    // stop and start together in IDLE stays idle
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("stopstart.busy", 8'(busy), 8'd0);
    tick();
    chk("stopstart.busy2", 8'(busy), 8'd0);

    // start while busy is ignored
    do_start("rebusy");
    seg("rebusy.n1", 4, 3'd1, 1'b1, 1'b1, 4'd0);
    start = 1'b1;
    seg("rebusy.gap_a", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    start = 1'b0;
    seg("rebusy.gap_b", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    seg("rebusy.f1",    1, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("rebusy.n3",    3, 3'd3, 1'b1, 1'b1, 4'd1);
    do_stop("rebusy.stop");

    // pause while IDLE does not block start; it then freezes FETCH
    pause = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("idlepause.busy", 8'(busy), 8'd1);
    seg("idlepause.hold", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    pause = 1'b0;
    seg("idlepause.n1", 4, 3'd1, 1'b1, 1'b1, 4'd0);
    do_stop("idlepause.stop");

    // Write entry 1 while it plays: old data finishes, new data next pass
    loop = 1'b1;
    do_start("wr");
    seg("wr.n1",  4, 3'd1, 1'b1, 1'b1, 4'd0);
    seg("wr.gap", 2, 3'd0, 1'b0, 1'b1, 4'd0);
    seg("wr.f1",  1, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("wr.n3a", 2, 3'd3, 1'b1, 1'b1, 4'd1);
    wr_addr = 4'd1; wr_data = 6'o07; wr_en = 1'b1;
    seg("wr.n3b", 1, 3'd3, 1'b1, 1'b1, 4'd1);
    wr_en = 1'b0;
    seg("wr.n3c",  5, 3'd3, 1'b1, 1'b1, 4'd1);
    seg("wr.gap1", 2, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("wr.f2",   1, 3'd0, 1'b0, 1'b1, 4'd2);
    seg("wr.rest", 4, 3'd0, 1'b0, 1'b1, 4'd2);
    seg("wr.gap2", 2, 3'd0, 1'b0, 1'b1, 4'd2);
    seg("wr.wrap", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    seg("wr.p2n1", 4, 3'd1, 1'b1, 1'b1, 4'd0);
    seg("wr.p2g0", 2, 3'd0, 1'b0, 1'b1, 4'd0);
    seg("wr.p2f1", 1, 3'd0, 1'b0, 1'b1, 4'd1);
    seg("wr.n7",   4, 3'd7, 1'b1, 1'b1, 4'd1);
    seg("wr.p2g1", 1, 3'd0, 1'b0, 1'b1, 4'd1);
    do_stop("wr.stop");
    loop = 1'b0;
    wr(4'd1, 6'o13);

    // Reset during GAP; table survives for the next start
    do_start("rstgap");
    seg("rstgap.n1",  4, 3'd1, 1'b1, 1'b1, 4'd0);
    seg("rstgap.gap", 1, 3'd0, 1'b0, 1'b1, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstgap.note",    8'(note),    8'd0);
    chk("rstgap.tone_en", 8'(tone_en), 8'd0);
    chk("rstgap.busy",    8'(busy),    8'd0);
    chk("rstgap.done",    8'(done),    8'd0);
    chk("rstgap.cur_idx", 8'(cur_idx), 8'd0);
    tick();
    chk("rstgap.idle", 8'(busy), 8'd0);
    do_start("replay");
    play_pass("replay");
    chk_done("replay");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
